// File: rtl/alu_seq_top.sv
// alu_seq_top: button-sequenced ALU. Four synchronised, edge-detected buttons
// load operand A, operand B and the opcode, then execute. The result and the
// zero/carry/overflow flags are registered on the execute action.
module alu_seq_top #(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int NB_SYNC   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [NB_DATA-1:0] i_switch,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  input  logic               i_btn_exec,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_zero,
  output logic               o_carry,
  output logic               o_ovf,
  output logic               o_valid,
  output logic               o_err,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_A = 2'd1,
    ST_GOT_B = 2'd2,
    ST_READY = 2'd3
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(8'h20);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(8'h22);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(8'h24);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(8'h25);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(8'h26);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(8'h27);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(8'h03);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(8'h02);

  // Warm-up length: edge detection is enabled only once the edge flop holds the
  // first fully synchronised sample, so a button held through reset never pulses.
  localparam int unsigned LP_WARM = NB_SYNC + 1;
  localparam int unsigned LP_WW   = $clog2(LP_WARM + 1);
  localparam logic [NB_DATA-1:0] LP_NBD = NB_DATA'(NB_DATA);

  logic [3:0]              w_btn;
  logic [3:0][NB_SYNC-1:0] r_sync;
  logic [3:0]              r_prev;
  logic [3:0]              w_sync_q;
  logic [3:0]              w_pulse;
  logic [LP_WW-1:0]        r_warm;
  logic                    w_ready;

  state_t             r_state;
  logic [NB_DATA-1:0] r_a;
  logic [NB_DATA-1:0] r_b;
  logic [NB_OPCODE-1:0] r_op;
  logic [NB_DATA-1:0] r_result;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_valid;
  logic               r_err;

  logic [NB_DATA:0]   w_sum;
  logic [NB_DATA:0]   w_diff;
  logic [NB_DATA-1:0] w_res;
  logic               w_carry;
  logic               w_ovf;
  logic               w_legal;
  logic               w_big;

  assign w_btn   = {i_btn_exec, i_btn_op, i_btn_b, i_btn_a};
  assign w_ready = (r_warm == LP_WW'(LP_WARM));

  // Synchroniser outputs and single-cycle rising-edge pulses
  always_comb begin
    w_sync_q = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_sync_q[i] = r_sync[i][NB_SYNC-1];
    end
    w_pulse = w_sync_q & ~r_prev & {4{w_ready}};
  end

  // Synchroniser chains, edge flops and post-reset warm-up counter
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        r_sync[i] <= {r_sync[i][NB_SYNC-2:0], w_btn[i]};
      end
      r_prev <= w_sync_q;
      if (!w_ready) r_warm <= r_warm + LP_WW'(1);
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};
  assign w_big  = (r_b >= LP_NBD);

  // ALU: result and flags for the currently loaded operands and opcode
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_legal = 1'b1;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[NB_DATA-1:0];
        w_carry = w_sum[NB_DATA];
        w_ovf   = (r_a[NB_DATA-1] == r_b[NB_DATA-1]) &&
                  (w_sum[NB_DATA-1] != r_a[NB_DATA-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[NB_DATA-1:0];
        w_carry = w_diff[NB_DATA];
        w_ovf   = (r_a[NB_DATA-1] != r_b[NB_DATA-1]) &&
                  (w_diff[NB_DATA-1] != r_a[NB_DATA-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_SRA: w_res = w_big ? {NB_DATA{r_a[NB_DATA-1]}} : $unsigned($signed(r_a) >>> r_b);
      OP_SRL: w_res = w_big ? '0 : (r_a >> r_b);
      default: w_legal = 1'b0;
    endcase
  end

  // Sequencing FSM: one action per cycle, priority A > B > op > exec
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_pulse[0]) begin
      r_state <= ST_GOT_A;
      r_a     <= i_switch;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_pulse[1]) begin
      if (r_state != ST_IDLE) begin
        r_state <= ST_GOT_B;
        r_b     <= i_switch;
        r_valid <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (w_pulse[2]) begin
      if (r_state == ST_GOT_B || r_state == ST_READY) begin
        r_state <= ST_READY;
        r_op    <= i_switch[NB_OPCODE-1:0];
        r_valid <= 1'b0;
      end else begin
        r_err <= 1'b1;
      end
    end else if (w_pulse[3]) begin
      if (r_state == ST_READY) begin
        if (w_legal) begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_carry  <= w_carry;
          r_ovf    <= w_ovf;
          r_valid  <= 1'b1;
        end else begin
          r_result <= '0;
          r_zero   <= 1'b0;
          r_carry  <= 1'b0;
          r_ovf    <= 1'b0;
          r_valid  <= 1'b0;
          r_err    <= 1'b1;
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_carry  = r_carry;
  assign o_ovf    = r_ovf;
  assign o_valid  = r_valid;
  assign o_err    = r_err;
  assign o_state  = r_state;

endmodule
